// File: rtl/instr_fetch_pkg.sv
// Shared AHB encodings, fetch FSM states and the instruction buffer entry type
// for the AHB-Lite instruction fetch unit.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ERR1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous instruction buffer with push/pop/clear; head entry is read straight
// from the storage registers so it is valid the cycle after the push edge.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ahb.sv
// AHB-Lite instruction fetch master: one word read per accepted PC, buffered with its PC for decode.
// Optional macro IFU_STALL_CNT_EN adds stall_cnt_out (fetch requested but no instruction valid).
module instr_fetch_ahb
    import instr_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] i_addr_in,
    input  logic        fetch_req_in,
    input  logic        flush_in,
    input  logic        misaligned_instr_in,
    input  logic        instr_ready_in,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic [2:0]  hsize_out,
    input  logic        hready_in,
    input  logic        hresp_in,
    input  logic [31:0] hrdata_in,
    output logic        ahb_ready_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        instr_valid_out,
    output logic        instr_fault_out
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_out
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic [31:0]        tag_q;
    logic               drop_q;
    logic [31:0]        last_addr_q;

    logic [31:0]        addr_aligned;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   eff_count;
    logic [OCC_W-1:0]   occupancy;
    logic               issue_allowed;
    logic               beat_done;
    logic               beat_fault;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    fetch_entry_t       fifo_head;
    fetch_entry_t       push_entry;

    assign hsize_out    = HSIZE_WORD;
    assign addr_aligned = {i_addr_in[31:2], 2'b00};

    // A flush empties the buffer at this edge, so the redirect target may issue immediately.
    assign eff_count     = flush_in ? '0 : fifo_count;
    assign occupancy     = OCC_W'(eff_count) + OCC_W'(state_q != IDLE);
    assign issue_allowed = rst_n_in && fetch_req_in && !misaligned_instr_in &&
                           (state_q != ERR1) && (occupancy < OCC_W'(FIFO_DEPTH));

    // Address phase drive and data-phase tracking FSM.
    always_comb begin
        state_d       = state_q;
        htrans_out    = HTRANS_IDLE;
        haddr_out     = last_addr_q;
        ahb_ready_out = 1'b0;
        beat_done     = 1'b0;
        beat_fault    = 1'b0;

        if (issue_allowed) begin
            htrans_out    = HTRANS_NONSEQ;
            haddr_out     = addr_aligned;
            ahb_ready_out = hready_in;
        end

        case (state_q)
            IDLE: begin
                if (ahb_ready_out) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (hready_in) begin
                    beat_done  = 1'b1;
                    beat_fault = hresp_in;
                    state_d    = ahb_ready_out ? DATA : IDLE;
                end else if (hresp_in) begin
                    state_d = ERR1;
                end
            end
            ERR1: begin
                if (hready_in) begin
                    beat_done  = 1'b1;
                    beat_fault = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            drop_q      <= 1'b0;
            last_addr_q <= BOOT_ADDRESS;
        end else begin
            state_q <= state_d;
            if (issue_allowed) begin
                last_addr_q <= addr_aligned;
            end
            if (ahb_ready_out) begin
                tag_q  <= i_addr_in;
                drop_q <= 1'b0;
            end else if (flush_in) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Completed beats are discarded when a redirect happened after their address phase.
    assign fifo_push        = beat_done && !drop_q && !flush_in;
    assign push_entry.pc    = tag_q;
    assign push_entry.instr = beat_fault ? NOP_INSTR : hrdata_in;
    assign push_entry.fault = beat_fault;
    assign fifo_pop         = instr_valid_out && instr_ready_in;

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .clear     (flush_in),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_valid_out = !fifo_empty;
    assign instr_out       = fifo_head.instr;
    assign instr_pc_out    = fifo_head.pc;
    assign instr_fault_out = fifo_head.fault;

    // Issue throttling must never let a beat land in a full buffer without a pop.
    no_overflow_a: assert property (@(posedge clk_in) disable iff (!rst_n_in)
                                    !(fifo_full && fifo_push && !fifo_pop));

`ifdef IFU_STALL_CNT_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_cnt_out <= '0;
        end else if (fetch_req_in && !instr_valid_out) begin
            stall_cnt_out <= stall_cnt_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_ahb.sv
// Directed bench for instr_fetch_ahb with a one-beat AHB slave model returning
// {16'hC0DE, addr[15:0]} for each read.
module tb_instr_fetch_ahb;
    import instr_fetch_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] i_addr_in;
    logic        fetch_req_in;
    logic        flush_in;
    logic        misaligned_instr_in;
    logic        instr_ready_in;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic [2:0]  hsize_out;
    logic        hready_in;
    logic        hresp_in;
    logic [31:0] hrdata_in;
    logic        ahb_ready_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_valid_out;
    logic        instr_fault_out;
`ifdef IFU_STALL_CNT_EN
    logic [31:0] stall_cnt_out;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        dp_pend = 1'b0;
    logic [31:0] dp_addr = '0;
    logic [31:0] data_xor = '0;

    always #5 clk_in = ~clk_in;

    assign hrdata_in = dp_pend ? ({16'hC0DE, dp_addr[15:0]} ^ data_xor) : 32'h0;

    instr_fetch_ahb dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .i_addr_in           (i_addr_in),
        .fetch_req_in        (fetch_req_in),
        .flush_in            (flush_in),
        .misaligned_instr_in (misaligned_instr_in),
        .instr_ready_in      (instr_ready_in),
        .haddr_out           (haddr_out),
        .htrans_out          (htrans_out),
        .hsize_out           (hsize_out),
        .hready_in           (hready_in),
        .hresp_in            (hresp_in),
        .hrdata_in           (hrdata_in),
        .ahb_ready_out       (ahb_ready_out),
        .instr_out           (instr_out),
        .instr_pc_out        (instr_pc_out),
        .instr_valid_out     (instr_valid_out),
        .instr_fault_out     (instr_fault_out)
`ifdef IFU_STALL_CNT_EN
        ,
        .stall_cnt_out       (stall_cnt_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; the slave model records accepted address phases and completed beats.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic        done;
        #1;
        acc  = ahb_ready_out;
        a    = haddr_out;
        done = dp_pend && hready_in;
        @(posedge clk_in);
        #1;
        if (done) dp_pend = 1'b0;
        if (acc) begin
            dp_pend = 1'b1;
            dp_addr = a;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in            = 1'b0;
        i_addr_in           = 32'h0000_1234;
        fetch_req_in        = 1'b1;
        flush_in            = 1'b0;
        misaligned_instr_in = 1'b0;
        instr_ready_in      = 1'b0;
        hready_in           = 1'b1;
        hresp_in            = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        check("rst_htrans", 32'(htrans_out), 32'(HTRANS_IDLE));
        check("rst_haddr", haddr_out, 32'h0000_0000);
        check("rst_ahb_ready", 32'(ahb_ready_out), 32'd0);
        check("rst_valid", 32'(instr_valid_out), 32'd0);
        check("rst_fault", 32'(instr_fault_out), 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_pc", instr_pc_out, 32'd0);
        check("hsize", 32'(hsize_out), 32'd2);

        // First fetch after reset release
        rst_n_in  = 1'b1;
        i_addr_in = 32'h0;
        #1;
        check("c1_htrans", 32'(htrans_out), 32'(HTRANS_NONSEQ));
        check("c1_haddr", haddr_out, 32'h0);
        check("c1_ahb_ready", 32'(ahb_ready_out), 32'd1);
        tick();
        fetch_req_in = 1'b0;
        #1;
        check("c2_valid", 32'(instr_valid_out), 32'd0);
        tick();
        check("c3_valid", 32'(instr_valid_out), 32'd1);
        check("c3_pc", instr_pc_out, 32'h0);
        check("c3_instr", instr_out, 32'hC0DE_0000);
        check("c3_fault", 32'(instr_fault_out), 32'd0);
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;
        #1;
        check("c4_valid", 32'(instr_valid_out), 32'd0);

        // Back-to-back 0,4,8 with decode stalled
        fetch_req_in = 1'b1;
        i_addr_in    = 32'h0;
        #1;
        check("b2b0_ready", 32'(ahb_ready_out), 32'd1);
        tick();
        i_addr_in = 32'h4;
        #1;
        check("b2b4_ready", 32'(ahb_ready_out), 32'd1);
        check("b2b4_haddr", haddr_out, 32'h4);
        tick();
        i_addr_in = 32'h8;
        #1;
        check("b2b8_htrans", 32'(htrans_out), 32'(HTRANS_IDLE));
        check("b2b8_ready", 32'(ahb_ready_out), 32'd0);
        check("b2b8_haddr_hold", haddr_out, 32'h4);
        tick();
        check("full_htrans", 32'(htrans_out), 32'(HTRANS_IDLE));
        check("full_ready", 32'(ahb_ready_out), 32'd0);
        check("full_head_pc", instr_pc_out, 32'h0);
        tick();
        check("full2_ready", 32'(ahb_ready_out), 32'd0);
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;
        #1;
        check("after_pop_ready", 32'(ahb_ready_out), 32'd1);
        check("after_pop_haddr", haddr_out, 32'h8);
        check("after_pop_head_pc", instr_pc_out, 32'h4);
        check("after_pop_head_instr", instr_out, 32'hC0DE_0004);
        tick();
        fetch_req_in = 1'b0;
        tick();
        instr_ready_in = 1'b1;
        #1;
        check("drain_pc4", instr_pc_out, 32'h4);
        tick();
        check("drain_pc8", instr_pc_out, 32'h8);
        check("drain_instr8", instr_out, 32'hC0DE_0008);
        tick();
        check("drain_empty", 32'(instr_valid_out), 32'd0);
        instr_ready_in = 1'b0;

        // Wait states in the data phase
        fetch_req_in = 1'b1;
        i_addr_in    = 32'h20;
        #1;
        tick();
        fetch_req_in = 1'b0;
        hready_in    = 1'b0;
        data_xor     = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_no_push", 32'(instr_valid_out), 32'd0);
        end
        hready_in = 1'b1;
        data_xor  = 32'h0;
        tick();
        check("ws_valid", 32'(instr_valid_out), 32'd1);
        check("ws_pc", instr_pc_out, 32'h20);
        check("ws_instr", instr_out, 32'hC0DE_0020);
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;

        // Two-cycle ERROR response on 0x40
        fetch_req_in = 1'b1;
        i_addr_in    = 32'h40;
        #1;
        tick();
        fetch_req_in = 1'b0;
        hready_in    = 1'b0;
        hresp_in     = 1'b1;
        tick();
        fetch_req_in = 1'b1;
        i_addr_in    = 32'h44;
        hready_in    = 1'b1;
        #1;
        check("err1_htrans", 32'(htrans_out), 32'(HTRANS_IDLE));
        check("err1_ready", 32'(ahb_ready_out), 32'd0);
        check("err1_no_push", 32'(instr_valid_out), 32'd0);
        tick();
        fetch_req_in = 1'b0;
        hresp_in     = 1'b0;
        #1;
        check("err_valid", 32'(instr_valid_out), 32'd1);
        check("err_pc", instr_pc_out, 32'h40);
        check("err_instr", instr_out, 32'h0000_0013);
        check("err_fault", 32'(instr_fault_out), 32'd1);
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;
        check("err_popped", 32'(instr_valid_out), 32'd0);

        // Flush with one buffered and one in flight
        fetch_req_in = 1'b1;
        i_addr_in    = 32'h60;
        #1;
        tick();
        i_addr_in = 32'h64;
        #1;
        tick();
        check("fl_buffered", 32'(instr_valid_out), 32'd1);
        flush_in  = 1'b1;
        i_addr_in = 32'h100;
        hready_in = 1'b0;
        tick();
        flush_in  = 1'b0;
        hready_in = 1'b1;
        #1;
        check("fl_cleared", 32'(instr_valid_out), 32'd0);
        check("fl_issue_ready", 32'(ahb_ready_out), 32'd1);
        check("fl_issue_haddr", haddr_out, 32'h100);
        tick();
        fetch_req_in = 1'b0;
        #1;
        check("fl_dropped", 32'(instr_valid_out), 32'd0);
        tick();
        check("fl_new_valid", 32'(instr_valid_out), 32'd1);
        check("fl_new_pc", instr_pc_out, 32'h100);
        check("fl_new_instr", instr_out, 32'hC0DE_0100);
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;

        // Misaligned PC is never issued
        fetch_req_in        = 1'b1;
        misaligned_instr_in = 1'b1;
        i_addr_in           = 32'h102;
        #1;
        check("mis_htrans", 32'(htrans_out), 32'(HTRANS_IDLE));
        check("mis_ready", 32'(ahb_ready_out), 32'd0);
        tick();
        tick();
        check("mis_no_fetch", 32'(instr_valid_out), 32'd0);
        fetch_req_in        = 1'b0;
        misaligned_instr_in = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
